neosd_card_cmd: RTL and testbench
=================================

# neosd_card_cmd

SD-card-side CMD-line responder: the far end of the host command FSM. It receives 48-bit host commands on CMD and checks framing and CRC7. Valid commands go to card logic; the block then serialises that logic's R1/R3/R6/R7 (48-bit) or R2 (136-bit) response back to the host. It is used in the synthesizable SD card model that drives host-controller regression and FPGA loopback.

## Interface
- NCR_MIN, 2, minimum SD clocks between the command end bit and the response start bit.
- NCR_MAX, 64, SD clocks to wait for card logic before abandoning the response.
- clk_i  in  1  system clock; must be ≥6× the sd_clk_i frequency.
- rstn_i  in  1  reset, asynchronous, active-low.
- sd_clk_i  in  1  SD clock from host; asynchronous, 2-FF synchronised internally.
- sd_cmd_i  in  1  CMD line input; 2-FF synchronised.
- sd_cmd_o  out  1  CMD line output data.
- sd_cmd_oe  out  1  CMD output enable.
- cmd_valid_o  out  1  one-cycle pulse: a valid command was received.
- cmd_idx_o  out  6  command index; held until the next valid command.
- cmd_arg_o  out  32  command argument; held until the next valid command.
- cmd_err_o  out  1  one-cycle pulse: bad CRC7, transmission bit or end bit.
- resp_valid_i  in  1  card logic presents a response; accepted only in WAIT_RESP.
- resp_kind_i  in  2  00 no response; 01 48-bit with generated CRC7; 10 48-bit with CRC field 7'h7F (R3); 11 136-bit R2.
- resp_data_i  in  127  48-bit: [37:32] index, [31:0] argument. R2: [126:0] = CID/CSD[127:1], with CRC supplied by card logic.
- resp_timeout_o  out  1  one-cycle pulse: NCR_MAX expired with no response.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Edge detect: the synchronised sd_clk delayed by one flop gives rise/fall strobes, each one clk_i cycle wide.
- sd_cmd_i is sampled only on rise strobes. sd_cmd_o/sd_cmd_oe change only on fall strobes.
- IDLE: on a rise with CMD=0 (start bit), clear the CRC7 and bit counter and go to RX.
- RX: shift 47 further bits on successive rises.
  - CRC7 (x^7+x^3+1, register reset 0) runs over bits 47..8: start, transmission, index, argument.
  - After bit 0 is sampled, go to CHECK.
- CHECK (1 clk_i cycle): the command is good if the transmission bit = 1, the received CRC = computed CRC, and the end bit = 1.
  - Good: pulse cmd_valid_o, update cmd_idx_o/cmd_arg_o, clear the NCR counter, go to WAIT_RESP.
  - Bad: pulse cmd_err_o, leave the outputs unchanged, go to IDLE.
- WAIT_RESP: the NCR counter increments on each rise and saturates at NCR_MAX.
  - The first resp_valid_i is latched into a 136-bit shift register. Later resp_valid_i pulses are ignored until IDLE.
  - resp_kind_i=00: go to IDLE the next cycle.
  - Otherwise, on the first fall with counter ≥ NCR_MIN and a response latched, drive oe=1 with the start bit 0, then go to TX.
  - If the counter reaches NCR_MAX with nothing latched: pulse resp_timeout_o, go to IDLE.
  - CMD line activity in WAIT_RESP is ignored.
- TX: one bit per fall, MSB first.
  - 48-bit frame: 0, 0, index[5:0], arg[31:0], CRC7, 1.
  - Generated CRC7 covers the first 40 bits; kind 10 sends 7'h7F instead.
  - R2 frame: 0, 0, 6'b111111, resp_data_i[126:0], 1.
- RELEASE: on the fall after the end bit, oe=0 and sd_cmd_o=1; go to IDLE.
- A resp_valid_i outside WAIT_RESP is dropped silently.

## Timing
- Reset values: sd_cmd_o=1, sd_cmd_oe=0, cmd_valid_o=0, cmd_err_o=0, resp_timeout_o=0, busy_o=0, cmd_idx_o=0, cmd_arg_o=0, state IDLE. Reset mid-TX releases the CMD line immediately.
- Input latency: 2 sync flops + 1 edge flop, i.e. each rise/fall strobe appears 3 clk_i cycles after the sd_clk_i edge.
- cmd_valid_o/cmd_err_o: 2 clk_i cycles after the rise strobe that samples the end bit.
- NCR as seen by the host = NCR_MIN..NCR_MAX SD clocks after the end bit. The minimum is met even if resp_valid_i arrives on the same cycle as cmd_valid_o.
- Bit counts: 48 or 136 falls with oe=1, then one release fall. Never more than one frame per command.

## Test plan
- Host sends CMD0, 40 00 00 00 00 95 -> cmd_valid_o pulse, idx=0, arg=0; card logic answers kind 00 -> oe stays 0, busy_o low 1 cycle after CHECK.
- CMD8, 48 00 00 01 AA 87; response kind 01 idx=8 arg=0x1AA -> 48-bit frame matching the golden-model CRC7, start bit exactly NCR_MIN SD clocks after the end bit, oe drops on the following fall.
- CMD8 with the CRC byte corrupted to 0x85 -> cmd_err_o pulse, no cmd_valid_o, no CMD drive, cmd_arg_o keeps its previous value.
- CMD55 (77 00 00 00 00 65) with no resp_valid_i -> resp_timeout_o after 64 rises, IDLE; the following CMD0 is decoded correctly.
- CMD2; R2 with resp_data_i = 127'h1 pattern -> 136 bits, the 6'b111111 field present, end bit 1; a second resp_valid_i during TX is ignored.
- Assert rstn_i low at TX bit 20 of an R1 -> oe=0 and sd_cmd_o=1 within the reset cycle; after release, a CMD0 is received normally.

Source files
------------

// File: rtl/neosd_card_cmd.sv
// neosd_card_cmd: SD card CMD-line responder. Receives 48-bit host commands,
// checks framing and CRC7, and serialises the card logic's R1/R3/R6/R7/R2 response.
module neosd_card_cmd #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         sd_clk_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_err_o,
  input  logic         resp_valid_i,
  input  logic [1:0]   resp_kind_i,
  input  logic [126:0] resp_data_i,
  output logic         resp_timeout_o,
  output logic         busy_o
);
  typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RESP, TX, RELEASE} state_t;
  localparam logic [6:0] MIN7 = 7'(NCR_MIN);
  localparam logic [6:0] MAX7 = 7'(NCR_MAX);

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ({7{b ^ c[6]}} & 7'h09);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  logic [2:0]   sclk_q;
  logic [1:0]   scmd_q;
  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [6:0]   crc_q, crc_d;
  logic [47:0]  rx_q, rx_d;
  logic [6:0]   ncr_q, ncr_d;
  logic         lat_q, lat_d, long_q, long_d;
  logic [135:0] tx_q, tx_d;
  logic         cmd_o_q, cmd_o_d, oe_q, oe_d;
  logic         valid_q, valid_d, err_q, err_d, tmo_q, tmo_d;
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  arg_q, arg_d;
  logic         rise, fall, cmd_bit;
  logic [39:0]  hdr40;
  logic [47:0]  resp48;

  // sclk_q[1:0] is the synchroniser, sclk_q[2] the edge-detect delay
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      sclk_q <= '0;
      scmd_q <= '1;
    end else begin
      sclk_q <= {sclk_q[1:0], sd_clk_i};
      scmd_q <= {scmd_q[0], sd_cmd_i};
    end

  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign fall    = ~sclk_q[1] & sclk_q[2];
  assign cmd_bit = scmd_q[1];
  assign hdr40   = {2'b00, resp_data_i[37:0]};
  assign resp48  = {hdr40, (resp_kind_i == 2'b10) ? 7'h7f : crc7_40(hdr40), 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    ncr_d   = ncr_q;
    lat_d   = lat_q;
    long_d  = long_q;
    tx_d    = tx_q;
    cmd_o_d = cmd_o_q;
    oe_d    = oe_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: if (rise && !cmd_bit) begin
        cnt_d   = 8'd1;
        crc_d   = '0;
        rx_d    = {rx_q[46:0], 1'b0};
        state_d = RX;
      end
      RX: if (rise) begin
        rx_d  = {rx_q[46:0], cmd_bit};
        cnt_d = cnt_q + 8'd1;
        crc_d = (cnt_q < 8'd40) ? crc7_step(crc_q, cmd_bit) : crc_q;
        state_d = (cnt_q == 8'd47) ? CHECK : RX;
      end
      CHECK: if (rx_q[46] && rx_q[7:1] == crc_q && rx_q[0]) begin
        valid_d = 1'b1;
        idx_d   = rx_q[45:40];
        arg_d   = rx_q[39:8];
        ncr_d   = '0;
        lat_d   = 1'b0;
        state_d = WAIT_RESP;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      WAIT_RESP: begin
        ncr_d = (rise && ncr_q < MAX7) ? ncr_q + 7'd1 : ncr_q;
        if (resp_valid_i && !lat_q) begin
          state_d = (resp_kind_i == 2'b00) ? IDLE : WAIT_RESP;
          lat_d   = resp_kind_i != 2'b00;
          long_d  = resp_kind_i == 2'b11;
          tx_d    = (resp_kind_i == 2'b11) ? {2'b00, 6'h3f, resp_data_i, 1'b1} : {resp48, 88'b0};
        end else if (lat_q && fall && ncr_q >= MIN7) begin
          oe_d    = 1'b1;
          cmd_o_d = tx_q[135];
          tx_d    = {tx_q[134:0], 1'b0};
          cnt_d   = 8'd1;
          state_d = TX;
        end else if (!lat_q && ncr_q == MAX7) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX: if (fall) begin
        cmd_o_d = tx_q[135];
        tx_d    = {tx_q[134:0], 1'b0};
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q + 8'd1 == (long_q ? 8'd136 : 8'd48)) ? RELEASE : TX;
      end
      RELEASE: if (fall) begin
        oe_d    = 1'b0;
        cmd_o_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
      rx_q    <= '0;
      ncr_q   <= '0;
      lat_q   <= 1'b0;
      long_q  <= 1'b0;
      tx_q    <= '0;
      cmd_o_q <= 1'b1;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      idx_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      ncr_q   <= ncr_d;
      lat_q   <= lat_d;
      long_q  <= long_d;
      tx_q    <= tx_d;
      cmd_o_q <= cmd_o_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
    end

  assign sd_cmd_o       = cmd_o_q;
  assign sd_cmd_oe      = oe_q;
  assign cmd_valid_o    = valid_q;
  assign cmd_err_o      = err_q;
  assign resp_timeout_o = tmo_q;
  assign cmd_idx_o      = idx_q;
  assign cmd_arg_o      = arg_q;
  assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_neosd_card_cmd.sv
// tb_neosd_card_cmd: host + card-logic model around neosd_card_cmd; frames seen on
// the CMD line are compared with frames built from the protocol rules.
module tb_neosd_card_cmd;
  localparam int NCR_MIN = 2;
  localparam int NCR_MAX = 64;

  logic         clk_i, rstn_i, sd_clk_i, sd_cmd_i;
  logic         sd_cmd_o, sd_cmd_oe, cmd_valid_o, cmd_err_o, resp_timeout_o, busy_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         resp_valid_i;
  logic [1:0]   resp_kind_i;
  logic [126:0] resp_data_i;

  neosd_card_cmd #(.NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sd_clk_i(sd_clk_i), .sd_cmd_i(sd_cmd_i),
    .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .cmd_valid_o(cmd_valid_o),
    .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o), .cmd_err_o(cmd_err_o),
    .resp_valid_i(resp_valid_i), .resp_kind_i(resp_kind_i), .resp_data_i(resp_data_i),
    .resp_timeout_o(resp_timeout_o), .busy_o(busy_o)
  );

  int n_chk = 0, n_fail = 0;
  int rise_cnt = 0, end_rise = 0, start_rise = 0, tmo_rise = 0;
  int nvalid = 0, nerr = 0, ntmo = 0;
  bit cap[$];
  logic [5:0]  exp_idx = '0;
  logic [31:0] exp_arg = '0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  initial begin
    sd_clk_i = 1'b0;
    #3;
    forever #40 sd_clk_i = ~sd_clk_i;
  end

  // host side: sample the CMD line on every SD clock rise
  always @(posedge sd_clk_i) begin
    rise_cnt++;
    if (sd_cmd_oe === 1'b1) begin
      if (cap.size() == 0) start_rise = rise_cnt;
      cap.push_back(sd_cmd_o);
    end
  end

  always @(negedge clk_i) begin
    if (cmd_valid_o) nvalid++;
    if (cmd_err_o) nerr++;
    if (resp_timeout_o) begin
      ntmo++;
      tmo_rise = rise_cnt;
    end
  end

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--) if (v[i]) v[i-:8] = v[i-:8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic send(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk_i);
      sd_cmd_i = f[i];
      if (i == 0) end_rise = rise_cnt + 1;
    end
    @(negedge sd_clk_i);
    sd_cmd_i = 1'b1;
  endtask

  task automatic card(input bit has_resp, input int dly, input logic [1:0] kind, input logic [126:0] data);
    int n = 0;
    while (!(cmd_valid_o || cmd_err_o) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (cmd_valid_o && has_resp) begin
      repeat (dly) @(negedge clk_i);
      resp_valid_i = 1'b1;
      resp_kind_i  = kind;
      resp_data_i  = data;
      @(negedge clk_i);
      resp_valid_i = 1'b0;
      if (kind == 2'b00 && dly == 0) chk("busy_low", busy_o, 0);
    end
  endtask

  task automatic run(input string tag, input logic [47:0] f, input bit has_resp, input int dly,
                     input logic [1:0] kind, input logic [126:0] data);
    int v0, e0, t0, len;
    bit good;
    logic [135:0] got, exp;
    v0 = nvalid; e0 = nerr; t0 = ntmo;
    cap.delete();
    good = f[46] && f[0] && f[7:1] == ref_crc(f[47:8]);
    fork
      send(f);
      card(has_resp, dly, kind, data);
    join
    repeat (180) @(posedge sd_clk_i);
    @(negedge clk_i);
    if (good) begin
      exp_idx = f[45:40];
      exp_arg = f[39:8];
    end
    chk({tag, "_valid"}, nvalid - v0, good);
    chk({tag, "_err"}, nerr - e0, !good);
    chk({tag, "_idx"}, cmd_idx_o, exp_idx);
    chk({tag, "_arg"}, cmd_arg_o, exp_arg);
    len = (!good || !has_resp || kind == 2'b00) ? 0 : (kind == 2'b11) ? 136 : 48;
    chk({tag, "_len"}, cap.size(), len);
    if (len > 0 && cap.size() == len) begin
      got = '0;
      foreach (cap[i]) got = {got[134:0], cap[i]};
      exp = (kind == 2'b11) ? {2'b00, 6'h3f, data, 1'b1}
          : {88'b0, 2'b00, data[37:0], (kind == 2'b10) ? 7'h7f : ref_crc({2'b00, data[37:0]}), 1'b1};
      chk({tag, "_frame"}, got, exp);
      if (dly == 0) chk({tag, "_ncr"}, start_rise - end_rise, NCR_MIN + 1);
      else chk({tag, "_ncr_rng"}, (start_rise - end_rise >= NCR_MIN + 1) && (start_rise - end_rise <= NCR_MAX + 1), 1);
    end
    chk({tag, "_tmo"}, ntmo - t0, good && !has_resp);
    if (good && !has_resp) chk({tag, "_tmo_at"}, tmo_rise - end_rise, NCR_MAX);
  endtask

  initial begin
    logic [47:0]  f;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   kind;
    logic [126:0] data;
    int n, p, dly;
    bit has_resp;
    rstn_i = 1'b0; sd_cmd_i = 1'b1;
    resp_valid_i = 1'b0; resp_kind_i = '0; resp_data_i = '0;
    repeat (4) @(negedge clk_i);
    chk("rst_cmd_o", sd_cmd_o, 1);
    chk("rst_oe", sd_cmd_oe, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_pulses", {cmd_valid_o, cmd_err_o, resp_timeout_o}, 0);
    chk("rst_idx_arg", {cmd_idx_o, cmd_arg_o}, 0);
    rstn_i = 1'b1;
    repeat (10) @(negedge clk_i);

    run("cmd0", 48'h400000000095, 1, 0, 2'b00, '0);
    run("cmd8", 48'h48000001AA87, 1, 0, 2'b01, {89'b0, 6'd8, 32'h1AA});
    run("cmd8_bad", 48'h48000001AA85, 1, 0, 2'b01, {89'b0, 6'd8, 32'h1AA});
    run("cmd55", 48'h770000000065, 0, 0, 2'b00, '0);
    run("cmd0_post_tmo", 48'h400000000095, 1, 0, 2'b00, '0);
    fork
      run("cmd2_r2", 48'h42000000004D, 1, 0, 2'b11, 127'h1);
      begin
        n = 0;
        while (cap.size() < 30 && n < 20000) begin
          @(negedge clk_i);
          n++;
        end
        resp_valid_i = 1'b1; resp_kind_i = 2'b01; resp_data_i = '1;
        @(negedge clk_i);
        resp_valid_i = 1'b0;
      end
    join

    cap.delete();
    fork
      send(48'h48000001AA87);
      card(1, 0, 2'b01, {89'b0, 6'd8, 32'h1AA});
    join
    n = 0;
    while (cap.size() < 20 && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_tx_bit", cap.size(), 20);
    rstn_i = 1'b0;
    #1;
    chk("rst_tx_oe", sd_cmd_oe, 0);
    chk("rst_tx_cmd_o", sd_cmd_o, 1);
    chk("rst_tx_busy", busy_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    exp_idx = '0; exp_arg = '0;
    chk("rst_tx_arg", cmd_arg_o, 0);
    repeat (5) @(posedge sd_clk_i);
    run("cmd0_post_rst", 48'h400000000095, 1, 0, 2'b00, '0);

    for (int k = 0; k < 14; k++) begin
      idx = 6'($urandom);
      arg = $urandom;
      f = {1'b0, 1'b1, idx, arg, ref_crc({1'b0, 1'b1, idx, arg}), 1'b1};
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, 8);
        f[(p == 8) ? 46 : p] = ~f[(p == 8) ? 46 : p];
      end
      kind = 2'($urandom);
      has_resp = $urandom_range(0, 7) != 0;
      dly = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 200);
      data = {$urandom, $urandom, $urandom, $urandom};
      run("rnd", f, has_resp, dly, kind, data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
